// File: rtl/decode_stage_if.sv
// Fetch-to-decode, write-back and ID/EX bundle for the decode stage.
interface decode_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CTRL_W = 9
);
    logic [DATA_W-1:0] instruction;
    logic [DATA_W-1:0] Next_PC;
    logic              flush;
    logic              wb_we;
    logic [REG_AW-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              stall;
    logic [DATA_W-1:0] d_pc;
    logic [DATA_W-1:0] d_rs_data;
    logic [DATA_W-1:0] d_rt_data;
    logic [DATA_W-1:0] d_imm;
    logic [REG_AW-1:0] d_rs;
    logic [REG_AW-1:0] d_rt;
    logic [REG_AW-1:0] d_rd;
    logic [CTRL_W-1:0] d_ctrl;

    modport master (
        output instruction, Next_PC, flush, wb_we, wb_addr, wb_data,
        input  stall, d_pc, d_rs_data, d_rt_data, d_imm, d_rs, d_rt, d_rd, d_ctrl
    );

    modport slave (
        input  instruction, Next_PC, flush, wb_we, wb_addr, wb_data,
        output stall, d_pc, d_rs_data, d_rt_data, d_imm, d_rs, d_rt, d_rd, d_ctrl
    );
endinterface

// File: rtl/decode_stage.sv
// Instruction decode: control decode, 32x32 register file with write-through,
// load-use hazard stall and the ID/EX pipeline latch.
module decode_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned NREGS  = 32
) (
    input  logic           clk,
    input  logic           reset,
    decode_stage_if.slave  bus
);
    localparam int unsigned CTRL_W        = 9;
    localparam int unsigned IMM_W         = 16;
    localparam int unsigned OP_W          = 6;
    localparam int unsigned CTRL_MEM_READ = 7;

    localparam logic [OP_W-1:0] OP_R    = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;

    // {reg_write,mem_read,mem_write,mem_to_reg,alu_src,reg_dst,branch,alu_op[1:0]}
    localparam logic [CTRL_W-1:0] CTRL_R    = 9'b1_0_0_0_0_1_0_10;
    localparam logic [CTRL_W-1:0] CTRL_LW   = 9'b1_1_0_1_1_0_0_00;
    localparam logic [CTRL_W-1:0] CTRL_SW   = 9'b0_0_1_0_1_0_0_00;
    localparam logic [CTRL_W-1:0] CTRL_BEQ  = 9'b0_0_0_0_0_0_1_01;
    localparam logic [CTRL_W-1:0] CTRL_ADDI = 9'b1_0_0_0_1_0_0_00;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    logic [DATA_W-1:0] pc_q, pc_d, rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
    logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] rs, rt, rd;
    logic [IMM_W-1:0]  imm;
    logic [CTRL_W-1:0] ctrl;
    logic              uses_rt;
    logic [DATA_W-1:0] rs_data, rt_data;
    logic              stall_c;

    // Field decode, operand read with write-through, hazard check, next latch value.
    always_comb begin
        op      = bus.instruction[31:26];
        rs      = bus.instruction[25:21];
        rt      = bus.instruction[20:16];
        rd      = bus.instruction[15:11];
        imm     = bus.instruction[15:0];
        ctrl    = '0;
        uses_rt = 1'b0;
        case (op)
            OP_R:    begin ctrl = CTRL_R;   uses_rt = 1'b1; end
            OP_LW:   ctrl = CTRL_LW;
            OP_SW:   begin ctrl = CTRL_SW;  uses_rt = 1'b1; end
            OP_BEQ:  begin ctrl = CTRL_BEQ; uses_rt = 1'b1; end
            OP_ADDI: ctrl = CTRL_ADDI;
            default: ctrl = '0;
        endcase

        rs_data = '0;
        if (rs != '0) rs_data = (bus.wb_we && bus.wb_addr == rs) ? bus.wb_data : regs_q[rs];
        rt_data = '0;
        if (rt != '0) rt_data = (bus.wb_we && bus.wb_addr == rt) ? bus.wb_data : regs_q[rt];

        // rt of lw/addi is a destination, so only rs always counts as a source.
        stall_c = !reset && ctrl_q[CTRL_MEM_READ] && (rt_q != '0) &&
                  ((rt_q == rs) || ((rt_q == rt) && uses_rt));

        pc_d      = '0;
        rs_data_d = '0;
        rt_data_d = '0;
        imm_d     = '0;
        rs_d      = '0;
        rt_d      = '0;
        rd_d      = '0;
        ctrl_d    = '0;
        if (!bus.flush && !stall_c) begin
            pc_d      = bus.Next_PC;
            rs_data_d = rs_data;
            rt_data_d = rt_data;
            imm_d     = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
            rs_d      = rs;
            rt_d      = rt;
            rd_d      = rd;
            ctrl_d    = ctrl;
        end
    end

    // Register file write port; r0 is never written.
    always_comb begin
        regs_d = regs_q;
        if (bus.wb_we && bus.wb_addr != '0) regs_d[bus.wb_addr] = bus.wb_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            ctrl_q    <= '0;
        end else begin
            pc_q      <= pc_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            ctrl_q    <= ctrl_d;
        end
    end

    assign bus.stall     = stall_c;
    assign bus.d_pc      = pc_q;
    assign bus.d_rs_data = rs_data_q;
    assign bus.d_rt_data = rt_data_q;
    assign bus.d_imm     = imm_q;
    assign bus.d_rs      = rs_q;
    assign bus.d_rt      = rt_q;
    assign bus.d_rd      = rd_q;
    assign bus.d_ctrl    = ctrl_q;
endmodule

// File: tb/tb_decode_stage.sv
// Directed plus randomized check of decode_stage against an instruction-level model.
module tb_decode_stage;
    logic clk;
    logic reset;

    decode_stage_if bus ();
    decode_stage dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [8:0]  ctrl;
    } idex_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mreg [32];
    idex_t       exp_q;
    logic        last_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [8:0] mctrl(input logic [5:0] op);
        case (op)
            6'b000000: return 9'b100001010;
            6'b100011: return 9'b110110000;
            6'b101011: return 9'b001010000;
            6'b000100: return 9'b000000101;
            6'b001000: return 9'b100010000;
            default:   return 9'b000000000;
        endcase
    endfunction

    function automatic logic [31:0] mread(input logic [4:0] a, input logic we,
                                          input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (we && wa == a) return wd;
        return mreg[a];
    endfunction

    function automatic logic mstall(input logic [31:0] ins);
        logic [5:0] op;
        logic       reads_rt;
        op = ins[31:26];
        reads_rt = (op == 6'b000000) || (op == 6'b101011) || (op == 6'b000100);
        return exp_q.ctrl[7] && exp_q.rt != 5'd0 &&
               (exp_q.rt == ins[25:21] || (reads_rt && exp_q.rt == ins[20:16]));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
        exp_q = '0;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".pc"},      bus.d_pc,      exp_q.pc);
        chk({tag, ".rs_data"}, bus.d_rs_data, exp_q.rs_data);
        chk({tag, ".rt_data"}, bus.d_rt_data, exp_q.rt_data);
        chk({tag, ".imm"},     bus.d_imm,     exp_q.imm);
        chk({tag, ".rs"},      32'(bus.d_rs), 32'(exp_q.rs));
        chk({tag, ".rt"},      32'(bus.d_rt), 32'(exp_q.rt));
        chk({tag, ".rd"},      32'(bus.d_rd), 32'(exp_q.rd));
        chk({tag, ".ctrl"},    32'(bus.d_ctrl), 32'(exp_q.ctrl));
    endtask

    // One pipeline cycle; entered and left at posedge+1.
    task automatic cycle(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                         input logic fl, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd);
        idex_t nxt;
        logic  st;
        bus.instruction = ins;
        bus.Next_PC     = pc;
        bus.flush       = fl;
        bus.wb_we       = we;
        bus.wb_addr     = wa;
        bus.wb_data     = wd;
        #1;
        st = mstall(ins);
        last_stall = bus.stall;
        chk({tag, ".stall"}, 32'(bus.stall), 32'(st));
        nxt = '0;
        if (!fl && !st) begin
            nxt.pc      = pc;
            nxt.rs_data = mread(ins[25:21], we, wa, wd);
            nxt.rt_data = mread(ins[20:16], we, wa, wd);
            nxt.imm     = 32'($signed(ins[15:0]));
            nxt.rs      = ins[25:21];
            nxt.rt      = ins[20:16];
            nxt.rd      = ins[15:11];
            nxt.ctrl    = mctrl(ins[31:26]);
        end
        @(posedge clk);
        #1;
        exp_q = nxt;
        if (we && wa != 5'd0) mreg[wa] = wd;
        chk_all(tag);
    endtask

    function automatic logic [31:0] r_op(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'b000000, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    localparam logic [31:0] NOP = 32'hFC00_0000;

    initial begin
        logic [31:0] ins;
        logic [31:0] pc;
        logic        fl;
        logic [5:0]  ops [6];

        reset = 1'b1;
        bus.instruction = 32'd0;
        bus.Next_PC     = 32'd0;
        bus.flush       = 1'b0;
        bus.wb_we       = 1'b0;
        bus.wb_addr     = 5'd0;
        bus.wb_data     = 32'd0;
        last_stall      = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset");
        chk("reset.stall", 32'(bus.stall), 32'd0);
        reset = 1'b0;

        // Write-back then read, write-through bypass, r0 stays zero.
        cycle("wb_r5", NOP, 32'h4, 1'b0, 1'b1, 5'd5, 32'h1234);
        cycle("rd_r5", r_op(5'd5, 5'd0, 5'd1), 32'h8, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("t1.rs_data", bus.d_rs_data, 32'h1234);
        chk("t1.ctrl", 32'(bus.d_ctrl), 32'h10A);
        cycle("bypass", r_op(5'd7, 5'd0, 5'd2), 32'hC, 1'b0, 1'b1, 5'd7, 32'hCAFE);
        chk("t2.bypass", bus.d_rs_data, 32'hCAFE);
        cycle("wb_r0", NOP, 32'h10, 1'b0, 1'b1, 5'd0, 32'hFFFF);
        cycle("rd_r0", r_op(5'd0, 5'd0, 5'd3), 32'h14, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("t2.r0", bus.d_rs_data, 32'd0);

        // Load-use on rs: one bubble, then the held add decodes.
        cycle("lw3", i_op(6'b100011, 5'd1, 5'd3, 16'h0), 32'h18, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle("add3_stall", r_op(5'd3, 5'd0, 5'd4), 32'h1C, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("t3.stall", 32'(last_stall), 32'd1);
        chk("t3.bubble", 32'(bus.d_ctrl), 32'd0);
        cycle("add3_go", r_op(5'd3, 5'd0, 5'd4), 32'h1C, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("t3.nostall", 32'(last_stall), 32'd0);
        chk("t3.ctrl", 32'(bus.d_ctrl), 32'h10A);
        cycle("lw0", i_op(6'b100011, 5'd1, 5'd0, 16'h0), 32'h20, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle("add0", r_op(5'd0, 5'd0, 5'd4), 32'h24, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("t3.r0_nostall", 32'(last_stall), 32'd0);

        // rt as a destination vs a source.
        cycle("lw4a", i_op(6'b100011, 5'd1, 5'd4, 16'h0), 32'h28, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle("addi4", i_op(6'b001000, 5'd1, 5'd4, 16'h5), 32'h2C, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("t4.addi_nostall", 32'(last_stall), 32'd0);
        cycle("lw4b", i_op(6'b100011, 5'd1, 5'd4, 16'h0), 32'h30, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle("sw4", i_op(6'b101011, 5'd1, 5'd4, 16'h0), 32'h34, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("t4.sw_stall", 32'(last_stall), 32'd1);

        // Flush while stalled, then an unknown opcode.
        cycle("lw4c", i_op(6'b100011, 5'd1, 5'd4, 16'h0), 32'h38, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle("flush", i_op(6'b101011, 5'd1, 5'd4, 16'h0), 32'h3C, 1'b1, 1'b0, 5'd0, 32'd0);
        chk("t5.flush_stall", 32'(last_stall), 32'd1);
        chk("t5.flush_bubble", 32'(bus.d_ctrl), 32'd0);
        cycle("after_flush", i_op(6'b001000, 5'd2, 5'd6, 16'h7), 32'h80, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("t5.next_pc", bus.d_pc, 32'h80);
        cycle("unknown", i_op(6'b111111, 5'd2, 5'd6, 16'h7), 32'h84, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("t5.unknown_ctrl", 32'(bus.d_ctrl), 32'd0);

        // Sign extension, then asynchronous reset in the middle of a stall.
        cycle("imm", i_op(6'b001000, 5'd0, 5'd1, 16'h8000), 32'h88, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("t6.imm", bus.d_imm, 32'hFFFF_8000);
        cycle("lw5", i_op(6'b100011, 5'd1, 5'd5, 16'h0), 32'h8C, 1'b0, 1'b0, 5'd0, 32'd0);
        bus.instruction = r_op(5'd5, 5'd0, 5'd1);
        bus.Next_PC     = 32'h90;
        #1;
        chk("t6.pre_stall", 32'(bus.stall), 32'd1);
        reset = 1'b1;
        #1;
        model_reset();
        chk_all("async_reset");
        chk("t6.reset_stall", 32'(bus.stall), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle("post_reset", r_op(5'd5, 5'd0, 5'd1), 32'h90, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("t6.post_nostall", 32'(last_stall), 32'd0);
        chk("t6.r5_cleared", bus.d_rs_data, 32'd0);

        // Random stream; fetch holds the instruction while stalled.
        ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
        ops[3] = 6'b000100; ops[4] = 6'b001000; ops[5] = 6'b000000;
        pc = 32'h1000;
        ins = NOP;
        fl = 1'b0;
        for (int n = 0; n < 400; n++) begin
            logic [5:0] op;
            if (!(last_stall && !fl)) begin
                op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
                ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
                pc = pc + 32'd4;
            end
            fl = ($urandom_range(0, 7) == 0);
            cycle("rand", ins, pc, fl, 1'($urandom), 5'($urandom_range(0, 7)), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
